// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch program counter.
// Selection encoding names which source loaded the PC on a given edge.
package pc_pkg;

    localparam int unsigned PC_WIDTH_DEFAULT = 36;
    localparam logic [PC_WIDTH_DEFAULT-1:0] RESET_VECTOR_DEFAULT = 36'd0;

    typedef logic [PC_WIDTH_DEFAULT-1:0] pc_t;

    typedef enum logic [2:0] {
        PC_SEL_RESET,
        PC_SEL_HOLD,
        PC_SEL_JUMP,
        PC_SEL_BRANCH,
        PC_SEL_INC
    } pc_sel_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC select: priority encode, increment with carry-out, mux; zero latency.
// Stall selects hold, so a stalled jump/branch target is dropped rather than queued.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned           PC_WIDTH     = PC_WIDTH_DEFAULT,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEFAULT),
    parameter int unsigned           STEP         = 1
) (
    input  logic                rst,
    input  logic                stall,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_next,
    output logic [PC_WIDTH-1:0] pc_plus_step,
    output pc_sel_e             sel,
    output logic                wrap_pending
);

    localparam logic [PC_WIDTH:0] STEP_EXT = (PC_WIDTH+1)'(STEP);

    logic [PC_WIDTH:0] sum;

    // The extra top bit is the carry-out that marks an increment wrapping past all-ones.
    assign sum          = {1'b0, pc} + STEP_EXT;
    assign pc_plus_step = sum[PC_WIDTH-1:0];

    always_comb begin
        sel = PC_SEL_INC;
        if (!rst) begin
            sel = PC_SEL_RESET;
        end else if (stall) begin
            sel = PC_SEL_HOLD;
        end else if (jump) begin
            sel = PC_SEL_JUMP;
        end else if (branch_taken) begin
            sel = PC_SEL_BRANCH;
        end
    end

    always_comb begin
        pc_next = pc_plus_step;
        case (sel)
            PC_SEL_RESET:  pc_next = RESET_VECTOR;
            PC_SEL_HOLD:   pc_next = pc;
            PC_SEL_JUMP:   pc_next = jump_target;
            PC_SEL_BRANCH: pc_next = branch_target;
            default:       pc_next = pc_plus_step;
        endcase
    end

    assign wrap_pending = (sel == PC_SEL_INC) && sum[PC_WIDTH];

endmodule

// File: rtl/program_counter.sv
// Fetch program counter registers; one cycle from controls to o_pc, no input-to-o_pc path.
// Stall holds the PC and drops any concurrent jump/branch request.
module program_counter
    import pc_pkg::*;
#(
    parameter int unsigned           PC_WIDTH     = PC_WIDTH_DEFAULT,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEFAULT),
    parameter int unsigned           STEP         = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_stall,
    input  logic                i_jump,
    input  logic [PC_WIDTH-1:0] i_jump_target,
    input  logic                i_branch_taken,
    input  logic [PC_WIDTH-1:0] i_branch_target,
    output logic [PC_WIDTH-1:0] o_pc,
    output logic [PC_WIDTH-1:0] o_pc_next,
    output logic [PC_WIDTH-1:0] o_pc_plus_step,
    output logic                o_wrap,
    output logic                o_redirect
);

    logic [PC_WIDTH-1:0] pc_q;
    logic                wrap_q;
    logic                redirect_q;
    logic [PC_WIDTH-1:0] pc_next;
    logic                wrap_pending;
    pc_sel_e             sel;

    pc_next_sel #(
        .PC_WIDTH     (PC_WIDTH),
        .RESET_VECTOR (RESET_VECTOR),
        .STEP         (STEP)
    ) u_next_sel (
        .rst           (i_rst),
        .stall         (i_stall),
        .jump          (i_jump),
        .jump_target   (i_jump_target),
        .branch_taken  (i_branch_taken),
        .branch_target (i_branch_target),
        .pc            (pc_q),
        .pc_next       (pc_next),
        .pc_plus_step  (o_pc_plus_step),
        .sel           (sel),
        .wrap_pending  (wrap_pending)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            pc_q       <= RESET_VECTOR;
            wrap_q     <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            pc_q       <= pc_next;
            wrap_q     <= wrap_pending;
            redirect_q <= (sel == PC_SEL_JUMP) || (sel == PC_SEL_BRANCH);
        end
    end

    assign o_pc       = pc_q;
    assign o_pc_next  = pc_next;
    assign o_wrap     = wrap_q;
    assign o_redirect = redirect_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed and random checks of program_counter against a behavioural PC model.
module tb_program_counter;
    import pc_pkg::*;

    localparam logic [35:0] ALL_ONES = 36'hF_FFFF_FFFF;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_jump = 1'b0;
    logic [35:0] i_jump_target = '0;
    logic        i_branch_taken = 1'b0;
    logic [35:0] i_branch_target = '0;
    logic [35:0] o_pc;
    logic [35:0] o_pc_next;
    logic [35:0] o_pc_plus_step;
    logic        o_wrap;
    logic        o_redirect;

    int total = 0;
    int bad = 0;

    pc_t m_pc;
    bit  m_known = 1'b0;

    program_counter dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_stall         (i_stall),
        .i_jump          (i_jump),
        .i_jump_target   (i_jump_target),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .o_pc            (o_pc),
        .o_pc_next       (o_pc_next),
        .o_pc_plus_step  (o_pc_plus_step),
        .o_wrap          (o_wrap),
        .o_redirect      (o_redirect)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive controls, check combinational outputs, then the registered result.
    task automatic cyc(input logic rst, input logic stall, input logic jump,
                       input logic [35:0] jt, input logic br, input logic [35:0] bt,
                       input bit glitch);
        pc_t exp_next;
        logic exp_wrap;
        logic exp_redir;
        @(negedge i_clk);
        i_rst = rst;
        i_stall = stall;
        i_jump = jump;
        i_jump_target = jt;
        i_branch_taken = br;
        i_branch_target = bt;
        #1;
        if (!rst)       exp_next = RESET_VECTOR_DEFAULT;
        else if (stall) exp_next = m_pc;
        else if (jump)  exp_next = jt;
        else if (br)    exp_next = bt;
        else            exp_next = m_pc + 36'd1;
        chk("pc_next", o_pc_next, exp_next);
        if (m_known) chk("pc_plus_step", o_pc_plus_step, m_pc + 36'd1);
        if (glitch) begin
            i_rst = 1'b0;
            #1;
            i_rst = rst;
        end
        @(posedge i_clk);
        #1;
        exp_wrap  = rst && !stall && !jump && !br && m_known && (m_pc == ALL_ONES);
        exp_redir = rst && !stall && (jump || br);
        m_pc = exp_next;
        m_known = 1'b1;
        chk("pc", o_pc, m_pc);
        chk("wrap", {35'd0, o_wrap}, {35'd0, exp_wrap});
        chk("redirect", {35'd0, o_redirect}, {35'd0, exp_redir});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1, 0, 0, '0, 0, '0, 0);
    endtask

    initial begin
        logic [35:0] jt, bt;
        logic rst, stall, jump, br;

        cyc(0, 0, 0, '0, 0, '0, 0);
        cyc(0, 0, 0, '0, 0, '0, 0);
        chk("reset_pc", o_pc, 36'd0);
        idle(3);
        chk("count_3", o_pc, 36'd3);

        idle(2);
        chk("at_5", o_pc, 36'd5);
        cyc(1, 1, 1, 36'h100, 0, '0, 0);
        cyc(1, 1, 1, 36'h100, 0, '0, 0);
        chk("stall_hold", o_pc, 36'd5);
        idle(1);
        chk("after_stall", o_pc, 36'd6);

        cyc(1, 0, 1, 36'h200, 1, 36'h300, 0);
        chk("jump_wins", o_pc, 36'h200);
        chk("redirect_set", {35'd0, o_redirect}, 36'd1);
        idle(1);
        chk("post_jump", o_pc, 36'h201);

        cyc(1, 0, 0, '0, 1, ALL_ONES, 0);
        chk("branch_all_ones", o_pc, ALL_ONES);
        chk("plus_step_wraps", o_pc_plus_step, 36'd0);
        idle(1);
        chk("wrapped_pc", o_pc, 36'd0);
        chk("wrap_set", {35'd0, o_wrap}, 36'd1);
        idle(1);

        cyc(1, 0, 1, 36'h1234, 0, '0, 0);
        cyc(0, 0, 1, 36'h5000, 0, '0, 0);
        chk("reset_over_jump", o_pc, 36'd0);
        cyc(1, 0, 0, '0, 0, '0, 1);
        chk("glitch_ignored", o_pc, 36'd1);

        for (int n = 0; n < 1000; n++) begin
            rst   = ($urandom_range(0, 31) != 0);
            stall = ($urandom_range(0, 3) == 0);
            jump  = ($urandom_range(0, 7) == 0);
            br    = ($urandom_range(0, 3) == 0);
            jt    = {$urandom_range(0, 15), $urandom};
            bt    = ($urandom_range(0, 1) == 0) ? (ALL_ONES - 36'($urandom_range(0, 3)))
                                                 : {$urandom_range(0, 15), $urandom};
            cyc(rst, stall, jump, jt, br, bt, ($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
